// File: rtl/sio_tx_framer_if.sv
// rtl/sio_tx_framer_if.sv - payload handshake bundle for the serial IO transmit framer
interface sio_tx_framer_if #(
    parameter int NBT = 40
);
    logic           wvalid;
    logic [NBT-1:0] wdata;
    logic           wready;

    // Payload source side
    modport master (
        output wvalid,
        output wdata,
        input  wready
    );

    // Framer side
    modport slave (
        input  wvalid,
        input  wdata,
        output wready
    );
endinterface

// File: rtl/sio_tx_framer.sv
// rtl/sio_tx_framer.sv - serial IO transmit framer, nibble stream plus tristate (optional SIO_TX_PARITY_EN)
module sio_tx_framer #(
    parameter int NBT  = 40,
    parameter int PRE  = 2,
    parameter int POST = 2,
    parameter int GAP  = 4
) (
    input  logic             c,
    input  logic             r,
    sio_tx_framer_if.slave   w,
    output logic [3:0]       td,
    output logic             t,
    output logic             busy,
    output logic             done
);

`ifdef SIO_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    // Start bit + payload (+ parity), padded with ones to a whole nibble
    localparam int NDATA = (NBT + 4 + PAR) / 4;
    localparam int SW    = 4 * NDATA;

    localparam int MAX_AB = (PRE > NDATA) ? PRE : NDATA;
    localparam int MAX_CD = (POST > GAP) ? POST : GAP;
    localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

    // Terminal counts; zero-length phases are never entered, so 0 is a safe stand-in
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(NDATA - 1);
    localparam logic [CW-1:0] POST_LAST = CW'((POST > 0) ? POST - 1 : 0);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_POST,
        S_GAP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   sh;
    logic [SW-1:0]   s_init;
    logic            wready_q;

    assign w.wready = wready_q;

    // Assemble the on-wire bit string from the payload: 0, wdata MSB first, (parity), ones
    always_comb begin
        s_init                 = '1;
        s_init[SW-1]           = 1'b0;
        s_init[SW-2 -: NBT]    = w.wdata;
`ifdef SIO_TX_PARITY_EN
        s_init[SW-2-NBT]       = ^w.wdata;
`endif
    end

    // Frame sequencer: all line and handshake outputs are registered here
    always_ff @(posedge c) begin
        if (r) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sh       <= '1;
            td       <= 4'hF;
            t        <= 1'b1;
            wready_q <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (w.wvalid && wready_q) begin
                        sh       <= s_init;
                        cnt      <= '0;
                        state    <= S_PRE;
                        t        <= 1'b0;
                        td       <= 4'hF;
                        wready_q <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                S_PRE: begin
                    if (cnt == PRE_LAST) begin
                        cnt   <= '0;
                        state <= S_DATA;
                        td    <= sh[SW-1 -: 4];
                        sh    <= {sh[SW-5:0], 4'hF};
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_DATA: begin
                    if (cnt == DATA_LAST) begin
                        cnt <= '0;
                        td  <= 4'hF;
                        if (POST > 0) begin
                            state <= S_POST;
                        end else begin
                            // No postamble: release the line straight after the last nibble
                            t    <= 1'b1;
                            done <= 1'b1;
                            if (GAP > 0) begin
                                state <= S_GAP;
                            end else begin
                                state    <= S_IDLE;
                                wready_q <= 1'b1;
                                busy     <= 1'b0;
                            end
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                        td  <= sh[SW-1 -: 4];
                        sh  <= {sh[SW-5:0], 4'hF};
                    end
                end

                S_POST: begin
                    if (cnt == POST_LAST) begin
                        cnt  <= '0;
                        t    <= 1'b1;
                        td   <= 4'hF;
                        done <= 1'b1;
                        if (GAP > 0) begin
                            state <= S_GAP;
                        end else begin
                            state    <= S_IDLE;
                            wready_q <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_GAP: begin
                    // done is a single pulse in the first released cycle
                    done <= 1'b0;
                    if (cnt == GAP_LAST) begin
                        cnt      <= '0;
                        state    <= S_IDLE;
                        wready_q <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    cnt      <= '0;
                    td       <= 4'hF;
                    t        <= 1'b1;
                    wready_q <= 1'b1;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sio_tx_framer.sv
// tb/tb_sio_tx_framer.sv - directed self-checking bench for sio_tx_framer
module tb_sio_tx_framer;

    logic       c;
    logic       r;
    logic [3:0] td;
    logic       t;
    logic       busy;
    logic       done;

    int checks;
    int failures;

    sio_tx_framer_if #(.NBT(40)) w_if ();

    sio_tx_framer #(
        .NBT  (40),
        .PRE  (2),
        .POST (2),
        .GAP  (4)
    ) dut (
        .c    (c),
        .r    (r),
        .w    (w_if.slave),
        .td   (td),
        .t    (t),
        .busy (busy),
        .done (done)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    // Observed line state packed as {t, td, wready, busy, done}
    function automatic logic [7:0] obs();
        return {t, td, w_if.wready, busy, done};
    endfunction

    function automatic logic [7:0] ev(input logic et, input logic [3:0] etd,
                                      input logic ewr, input logic eb, input logic ed);
        return {et, etd, ewr, eb, ed};
    endfunction

    localparam logic [7:0] IDLE_V = 8'b1_1111_1_0_0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected state of cycle A+k for a full frame with the given data nibbles
    function automatic logic [7:0] frame_exp(input int k, input logic [43:0] nib);
        logic [43:0] n;
        n = nib;
        if (k <= 2)       return ev(1'b0, 4'hF, 1'b0, 1'b1, 1'b0);
        else if (k <= 13) return ev(1'b0, n[4*(13-k) +: 4], 1'b0, 1'b1, 1'b0);
        else if (k <= 15) return ev(1'b0, 4'hF, 1'b0, 1'b1, 1'b0);
        else if (k == 16) return ev(1'b1, 4'hF, 1'b0, 1'b1, 1'b1);
        else if (k <= 19) return ev(1'b1, 4'hF, 1'b0, 1'b1, 1'b0);
        else              return IDLE_V;
    endfunction

    // Called at the negedge of the accept cycle A; returns at the negedge of A+20.
    // mode 0: drop wvalid after accept; 1: hold wvalid with altered data; 2: pulse wvalid during busy
    task automatic run_frame(input string tag, input logic [39:0] word,
                             input logic [43:0] nib, input int mode);
        w_if.wvalid = 1'b1;
        w_if.wdata  = word;
        check({tag, "_accept_ready"}, 64'(w_if.wready), 64'd1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge c);
            check($sformatf("%s_c%0d", tag, k), 64'(obs()), 64'(frame_exp(k, nib)));
            case (mode)
                0: w_if.wvalid = 1'b0;
                1: w_if.wdata  = ~word;
                default: begin
                    w_if.wvalid = (k < 19) ? k[0] : 1'b0;
                    w_if.wdata  = {$urandom, $urandom};
                end
            endcase
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        r           = 1'b1;
        w_if.wvalid = 1'b0;
        w_if.wdata  = '0;
        repeat (3) @(negedge c);
        r = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge c);
            check($sformatf("idle_%0d", i), 64'(obs()), 64'(IDLE_V));
        end

        run_frame("f_1234", 40'h123456789A, 44'h091A2B3C4D7, 0);
        run_frame("f_zero", 40'h0000000000, 44'h00000000007, 0);
        // Back-to-back: wvalid held high, second accept lands exactly at A+20
        run_frame("f_ones", 40'hFFFFFFFFFF, 44'h7FFFFFFFFFF, 1);
        run_frame("f_b2b",  40'h123456789A, 44'h091A2B3C4D7, 2);
`ifdef SIO_TX_PARITY_EN
        run_frame("f_par3", 40'h0000000003, 44'h0000000001B, 0);
`else
        run_frame("f_par3", 40'h0000000003, 44'h0000000001F, 0);
`endif
        // After wvalid pulses during busy, no extra frame starts
        for (int i = 0; i < 4; i++) begin
            @(negedge c);
            check($sformatf("no_extra_%0d", i), 64'(obs()), 64'(IDLE_V));
        end

        // Reset mid-data: r high during A+6, reset values from A+7, no done
        w_if.wvalid = 1'b1;
        w_if.wdata  = 40'h123456789A;
        for (int k = 1; k <= 12; k++) begin
            @(negedge c);
            w_if.wvalid = 1'b0;
            if (k <= 6)
                check($sformatf("rst_c%0d", k), 64'(obs()),
                      64'(frame_exp(k, 44'h091A2B3C4D7)));
            else
                check($sformatf("rst_c%0d", k), 64'(obs()), 64'(IDLE_V));
            r = (k == 6);
        end

        run_frame("f_post_rst", 40'h0000000000, 44'h00000000007, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Backstop so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
